xge_wb_regs: RTL
================

Name: xge_wb_regs

Overview:
- Wishbone slave register file on the MAC management port; consumes the wb_* cycles driven on the Wishbone interface and returns wb_ack_o, wb_dat_o and wb_int_o.
- Holds MAC configuration, a scratch register and sticky interrupt pending/mask logic, and exports a read-only view of core status.
- Sits between the Wishbone bus and the TX/RX datapath control inputs.

Parameters:
- NUM_INT, 8, number of interrupt sources (1..32)
- CFG_RST, 32'h0000_0003, reset value of CONFIG
- VERSION, 32'h0001_0000, constant returned at VERSION address

Ports:
- wb_clk_i  in  1  bus/register clock
- wb_rst_i  in  1  asynchronous active-high reset
- wb_adr_i  in  8  byte address; bits [1:0] ignored
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write, 0 = read
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  transfer acknowledge
- wb_dat_o  out  32  read data
- wb_int_o  out  1  interrupt request, level
- int_src_i  in  NUM_INT  interrupt event pulses from core; a bit high on a clock edge = one event
- status_i  in  32  core status, sampled on read
- cfg_o  out  32  CONFIG register contents to core

Behaviour:
- Reset (async assert, sync deassert on wb_clk_i): wb_ack_o=0, wb_dat_o=0, wb_int_o=0, cfg_o=CFG_RST, SCRATCH=0, PENDING=0, MASK=0.
- Accept: a transfer is accepted on a rising edge with wb_cyc_i & wb_stb_i & !wb_ack_o.
- Ack timing: wb_ack_o rises at the accepting edge and stays high for exactly one cycle. Latency is 1 cycle.
- Held strobe: if the master holds stb high, the next accept occurs the cycle after ack falls, giving one transfer every 2 cycles.
- cyc or stb low: no accept. If cyc drops while ack is high, ack still completes its single cycle and no state changes further.
- Writes take effect at the accepting edge.
- Reads: wb_dat_o is registered with ack and is valid only while wb_ack_o=1. It is 0 in all other cycles.
- Register map (adr[7:2]):
  - 0x00 CONFIG rw
  - 0x04 SCRATCH rw
  - 0x08 PENDING: read; write-1-to-clear bits [NUM_INT-1:0]
  - 0x0C MASK rw, bits [NUM_INT-1:0]; 1 = enabled
  - 0x10 RAW ro = int_src_i as sampled at the accept edge
  - 0x14 STATUS ro = status_i as sampled at the accept edge
  - 0x18 VERSION ro = VERSION
- Unused register bits read 0.
- Unmapped addresses read 0, writes are ignored, and the transfer is still acked; there is no error response.
- PENDING set: PENDING[i] sets on any edge where int_src_i[i]=1, and is sticky.
- PENDING set/clear collision: a W1C to bit i on the same edge that int_src_i[i]=1 leaves the bit SET (set wins).
- PENDING read/set collision: a read of PENDING on the same edge as a new event returns the pre-edge value. The new bit is visible on the next read.
- wb_int_o is a registered |(PENDING & MASK), one cycle behind the register contents.
  - Example: event at edge N → PENDING at N → wb_int_o at N+1.
  - Clearing the last pending bit or masking it drops wb_int_o one cycle after the write edge.
- Reset mid-transfer: ack drops immediately (async), the write is not performed if reset is asserted at that edge, and all registers return to reset values.

Test Plan:
- Reset, then read CONFIG, SCRATCH, PENDING, MASK and VERSION → 0x3, 0, 0, 0, 0x00010000; each read acked exactly one cycle after stb; wb_dat_o=0 outside ack.
- Write SCRATCH=0xDEADBEEF, read back → 0xDEADBEEF. Write CONFIG=0xA5 → cfg_o=0xA5 at the write-accept edge. Hold stb high for 4 cycles → exactly 2 acks (alternating cycles).
- Pulse int_src_i[3] for 1 cycle with MASK=0 → PENDING=0x08, wb_int_o stays 0. Write MASK=0x08 → wb_int_o=1 one cycle later. Write PENDING=0x08 → PENDING=0, wb_int_o=0 one cycle later.
- W1C PENDING=0x01 on the same edge as an int_src_i[0] pulse → PENDING[0] remains 1 and wb_int_o stays asserted with MASK[0]=1.
- Write then read address 0x40 → ack returned, read data 0; read STATUS with status_i=0x12345678 → 0x12345678.
- Assert wb_rst_i mid-write (cyc/stb high, before ack) → ack stays 0, target register keeps its reset value, and wb_int_o=0.

Source files
------------

// File: rtl/xge_wb_regs_if.sv
// ---------------------------------------------------------------------------
// xge_wb_regs_if
// Wishbone management-port bundle between a bus master and the xge_wb_regs
// register file.
//   wb_adr_i  [7:0]  byte address (bits [1:0] unused by the slave)
//   wb_cyc_i         bus cycle valid
//   wb_stb_i         strobe
//   wb_we_i          1 = write, 0 = read
//   wb_dat_i  [31:0] write data
//   wb_ack_o         transfer acknowledge (one cycle per transfer)
//   wb_dat_o  [31:0] read data, valid only while wb_ack_o is high
//   wb_int_o         level interrupt request
// ---------------------------------------------------------------------------
interface xge_wb_regs_if;
    logic [7:0]  wb_adr_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        wb_int_o;

    modport master (
        output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o, wb_int_o
    );

    modport slave (
        input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        output wb_ack_o, wb_dat_o, wb_int_o
    );
endinterface

// File: rtl/xge_wb_regs.sv
// ---------------------------------------------------------------------------
// xge_wb_regs
// Wishbone slave register file for the MAC management port. Holds the MAC
// CONFIG word, a SCRATCH register, sticky interrupt PENDING bits with a MASK,
// and read-only views of the raw interrupt sources, core status and VERSION.
//   wb_clk_i        bus/register clock
//   wb_rst_i        asynchronous active-high reset
//   wb              Wishbone slave bundle (xge_wb_regs_if.slave)
//   int_src_i       interrupt event pulses, one event per high clock edge
//   status_i [31:0] core status, sampled when a read is accepted
//   cfg_o    [31:0] CONFIG register contents driven to the core
// Register map (wb_adr_i[7:2]):
//   0x00 CONFIG rw, 0x04 SCRATCH rw, 0x08 PENDING r / W1C, 0x0C MASK rw,
//   0x10 RAW ro, 0x14 STATUS ro, 0x18 VERSION ro; others read 0.
// ---------------------------------------------------------------------------
module xge_wb_regs #(
    parameter int          NUM_INT = 8,
    parameter logic [31:0] CFG_RST = 32'h0000_0003,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    xge_wb_regs_if.slave       wb,
    input  logic [NUM_INT-1:0] int_src_i,
    input  logic [31:0]        status_i,
    output logic [31:0]        cfg_o
);

    localparam logic [5:0] ADR_CONFIG  = 6'h00;
    localparam logic [5:0] ADR_SCRATCH = 6'h01;
    localparam logic [5:0] ADR_PENDING = 6'h02;
    localparam logic [5:0] ADR_MASK    = 6'h03;
    localparam logic [5:0] ADR_RAW     = 6'h04;
    localparam logic [5:0] ADR_STATUS  = 6'h05;
    localparam logic [5:0] ADR_VERSION = 6'h06;

    logic               ack_q;
    logic [31:0]        dat_q;
    logic               int_q;
    logic [31:0]        cfg_q;
    logic [31:0]        scratch_q;
    logic [NUM_INT-1:0] pending_q;
    logic [NUM_INT-1:0] mask_q;

    logic               accept;
    logic               wr_en;
    logic [5:0]         reg_sel;
    logic [NUM_INT-1:0] w1c;
    logic [31:0]        rd_data;
    logic               unused_adr_bits;

    assign unused_adr_bits = ^wb.wb_adr_i[1:0];

    // Transfer decode. Gating accept with the current ack forces a gap cycle
    // between back-to-back transfers, so a held strobe yields one transfer
    // every two cycles. The read mux uses pre-edge register values, so a
    // PENDING read racing a new event returns the old contents.
    always_comb begin
        accept  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        wr_en   = accept & wb.wb_we_i;
        reg_sel = wb.wb_adr_i[7:2];
        w1c     = '0;
        rd_data = '0;
        if (wr_en && reg_sel == ADR_PENDING) begin
            w1c = wb.wb_dat_i[NUM_INT-1:0];
        end
        case (reg_sel)
            ADR_CONFIG:  rd_data = cfg_q;
            ADR_SCRATCH: rd_data = scratch_q;
            ADR_PENDING: rd_data[NUM_INT-1:0] = pending_q;
            ADR_MASK:    rd_data[NUM_INT-1:0] = mask_q;
            ADR_RAW:     rd_data[NUM_INT-1:0] = int_src_i;
            ADR_STATUS:  rd_data = status_i;
            ADR_VERSION: rd_data = VERSION;
            default:     rd_data = '0;
        endcase
    end

    // Bus response: ack is a single-cycle pulse per accepted transfer and the
    // read data is registered alongside it, forced to zero whenever no read
    // is being acknowledged.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            dat_q <= (accept && !wb.wb_we_i) ? rd_data : 32'h0;
        end
    end

    // Writable registers. Writes land on the accepting edge; unmapped and
    // read-only addresses simply fall through and change nothing.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cfg_q     <= CFG_RST;
            scratch_q <= '0;
            mask_q    <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                ADR_CONFIG:  cfg_q     <= wb.wb_dat_i;
                ADR_SCRATCH: scratch_q <= wb.wb_dat_i;
                ADR_MASK:    mask_q    <= wb.wb_dat_i[NUM_INT-1:0];
                default:     ;
            endcase
        end
    end

    // Sticky interrupt pending bits. The OR with int_src_i comes after the
    // clear so an event arriving on the same edge as a W1C keeps the bit set.
    // The interrupt line is registered from the current register contents,
    // which places it one cycle behind any PENDING or MASK change.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pending_q <= '0;
            int_q     <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~w1c) | int_src_i;
            int_q     <= |(pending_q & mask_q);
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_int_o = int_q;
    assign cfg_o       = cfg_q;

endmodule
